// File: rtl/keyboard_char_pkg.sv
// Shared scan-code (set 2) and ASCII constants, Caps Lock FSM encoding and the captured-character record.
// Pure declarations: no logic, no latency, no flow control.
package keyboard_char_pkg;

   localparam logic [8:0] SC_LSHIFT   = 9'h012;
   localparam logic [8:0] SC_RSHIFT   = 9'h059;
   localparam logic [8:0] SC_CAPS     = 9'h058;
   localparam logic [8:0] SC_ENTER    = 9'h05A;
   localparam logic [8:0] SC_KP_ENTER = 9'h15A;
   localparam logic [8:0] SC_SPACE    = 9'h029;
   localparam logic [8:0] SC_BKSP     = 9'h066;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_SP = 8'h20;

   localparam logic [0:0] CAPS_IDLE = 1'b0;
   localparam logic [0:0] CAPS_HELD = 1'b1;

   typedef struct packed {
      logic       vld;
      logic [7:0] ch;
   } char_t;

endpackage

// File: rtl/char_fifo.sv
// DEPTH x 8 show-ahead FIFO with occupancy count and sticky overflow.
// Latency: write visible at the head on the next cycle; no backpressure, a push into a full FIFO without a pop is dropped.
module char_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   always_comb begin
      empty   = (count == '0);
      full    = (count == FULL_CNT);
      do_pop  = rd_en && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      do_push = wr_en && (!full || do_pop);
      rd_data = empty ? 8'h00 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
         if (wr_en && !do_push) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/keystroke_char_buffer.sv
// Scan-code-set-2 key presses to ASCII (Shift, Caps Lock; SHIFT_SYMBOLS_EN adds shifted digit symbols), queued in a show-ahead FIFO.
// Latency 2 cycles key_valid -> rd_data; no backpressure, characters arriving while full are dropped and flag overflow.
module keystroke_char_buffer
   import keyboard_char_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_valid,
   input  logic [8:0]    last_change,
   input  logic [511:0]  key_down,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          caps_on,
   output logic          overflow
);

   function automatic char_t scan_to_ascii(input logic [8:0] code,
                                           input logic       shift,
                                           input logic       caps);
      char_t      r;
      logic [7:0] lo;
      logic [7:0] dg;
      r  = '{vld: 1'b0, ch: 8'h00};
      lo = 8'h00;
      dg = 8'h00;
      case (code)
         9'h01C: lo = "a";  9'h032: lo = "b";  9'h021: lo = "c";  9'h023: lo = "d";
         9'h024: lo = "e";  9'h02B: lo = "f";  9'h034: lo = "g";  9'h033: lo = "h";
         9'h043: lo = "i";  9'h03B: lo = "j";  9'h042: lo = "k";  9'h04B: lo = "l";
         9'h03A: lo = "m";  9'h031: lo = "n";  9'h044: lo = "o";  9'h04D: lo = "p";
         9'h015: lo = "q";  9'h02D: lo = "r";  9'h01B: lo = "s";  9'h02C: lo = "t";
         9'h03C: lo = "u";  9'h02A: lo = "v";  9'h01D: lo = "w";  9'h022: lo = "x";
         9'h035: lo = "y";  9'h01A: lo = "z";
         default: lo = 8'h00;
      endcase
      case (code)
         9'h045: dg = "0";  9'h016: dg = "1";  9'h01E: dg = "2";  9'h026: dg = "3";
         9'h025: dg = "4";  9'h02E: dg = "5";  9'h036: dg = "6";  9'h03D: dg = "7";
         9'h03E: dg = "8";  9'h046: dg = "9";
         default: dg = 8'h00;
      endcase
      if (lo != 8'h00) begin
         r.vld = 1'b1;
         r.ch  = (shift ^ caps) ? (lo - 8'h20) : lo;
      end else if (dg != 8'h00) begin
         r.vld = 1'b1;
         r.ch  = dg;
`ifdef SHIFT_SYMBOLS_EN
         if (shift) begin
            case (dg)
               "1": r.ch = "!";  "2": r.ch = "@";  "3": r.ch = "#";  "4": r.ch = "$";
               "5": r.ch = "%";  "6": r.ch = "^";  "7": r.ch = "&";  "8": r.ch = "*";
               "9": r.ch = "(";  default: r.ch = ")";
            endcase
         end
`endif
      end else begin
         case (code)
            SC_SPACE:             r = '{vld: 1'b1, ch: ASCII_SP};
            SC_ENTER, SC_KP_ENTER: r = '{vld: 1'b1, ch: ASCII_CR};
            SC_BKSP:              r = '{vld: 1'b1, ch: ASCII_BS};
            default:              r = '{vld: 1'b0, ch: 8'h00};
         endcase
      end
      return r;
   endfunction

   logic       shift;
   logic       press;
   char_t      map_c;
   logic       push_q;
   logic [7:0] ascii_q;
   logic [0:0] caps_st;

   always_comb begin
      shift = key_down[SC_LSHIFT] | key_down[SC_RSHIFT];
      press = key_valid & key_down[last_change];
      map_c = scan_to_ascii(last_change, shift, caps_on);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         push_q  <= 1'b0;
         ascii_q <= 8'h00;
      end else begin
         push_q  <= press & map_c.vld;
         ascii_q <= map_c.ch;
      end
   end

   // Only the first press after a release toggles, so typematic repeats of Caps are inert.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         caps_st <= CAPS_IDLE;
         caps_on <= 1'b0;
      end else if (key_valid && last_change == SC_CAPS) begin
         if (caps_st == CAPS_IDLE) begin
            if (press) begin
               caps_on <= ~caps_on;
               caps_st <= CAPS_HELD;
            end
         end else if (!press) begin
            caps_st <= CAPS_IDLE;
         end
      end
   end

   char_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (push_q),
      .wr_data  (ascii_q),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_keystroke_char_buffer.sv
// Randomized and directed bench: a queue-based reference model is checked against the DUT every cycle.
module tb_keystroke_char_buffer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_valid = 1'b0;
   logic [8:0]    last_change = 9'h000;
   logic [511:0]  key_down = '0;
   logic          rd_en = 1'b0;
   logic [7:0]    rd_data;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          caps_on;
   logic          overflow;

   keystroke_char_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .last_change (last_change),
      .key_down    (key_down),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .caps_on     (caps_on),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   logic [8:0] let_codes [26] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034,
                                  9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031,
                                  9'h044, 9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C,
                                  9'h02A, 9'h01D, 9'h022, 9'h035, 9'h01A};
   logic [8:0] dig_codes [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036,
                                  9'h03D, 9'h03E, 9'h046};
   logic [7:0] dig_sym   [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
                                  8'h26, 8'h2A, 8'h28};
   logic [8:0] misc_codes [8] = '{9'h029, 9'h05A, 9'h15A, 9'h066, 9'h058, 9'h174, 9'h11C, 9'h00E};

   // Reference: character the spec assigns to a press, or -1 for none.
   function automatic int model_char(input logic [8:0] code, input bit sh, input bit cp);
      for (int i = 0; i < 26; i++)
         if (code == let_codes[i]) return (sh ^ cp) ? 32'h41 + i : 32'h61 + i;
      for (int i = 0; i < 10; i++)
         if (code == dig_codes[i]) begin
`ifdef SHIFT_SYMBOLS_EN
            if (sh) return int'(dig_sym[i]);
`endif
            return 32'h30 + i;
         end
      if (code == 9'h029) return 32'h20;
      if (code == 9'h05A || code == 9'h15A) return 32'h0D;
      if (code == 9'h066) return 32'h08;
      return -1;
   endfunction

   byte unsigned m_q [$];
   bit           m_s1_vld = 1'b0;
   byte unsigned m_s1_ch  = 8'h00;
   bit           m_caps = 1'b0;
   bit           m_held = 1'b0;
   bit           m_ovf  = 1'b0;

   always @(posedge clk) begin
      bit pop_ok;
      bit sh;
      bit dn;
      int c;
      if (!rst_n) begin
         m_q.delete();
         m_s1_vld = 1'b0;
         m_caps   = 1'b0;
         m_held   = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         pop_ok = rd_en && (m_q.size() > 0);
         if (pop_ok) void'(m_q.pop_front());
         if (m_s1_vld) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_s1_ch);
            else m_ovf = 1'b1;
         end
         sh = key_down[9'h012] | key_down[9'h059];
         dn = key_down[last_change];
         c  = model_char(last_change, sh, m_caps);
         m_s1_vld = key_valid && dn && (c >= 0);
         m_s1_ch  = 8'(c);
         if (key_valid && last_change == 9'h058) begin
            if (dn && !m_held) begin
               m_caps = ~m_caps;
               m_held = 1'b1;
            end else if (!dn) begin
               m_held = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 32'(count), m_q.size());
         chk("empty", 32'(empty), 32'(m_q.size() == 0));
         chk("full", 32'(full), 32'(m_q.size() == DEPTH));
         chk("caps_on", 32'(caps_on), 32'(m_caps));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [8:0] code);
      key_down[code] = 1'b1;
      last_change    = code;
      key_valid      = 1'b1;
      tick();
      key_valid      = 1'b0;
      key_down[code] = 1'b0;
   endtask

   task automatic release_key(input logic [8:0] code);
      key_down[code] = 1'b0;
      last_change    = code;
      key_valid      = 1'b1;
      tick();
      key_valid      = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_sym;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst count", 32'(count), 0);
      chk("rst empty", 32'(empty), 1);
      chk("rst full", 32'(full), 0);
      chk("rst overflow", 32'(overflow), 0);
      chk("rst caps", 32'(caps_on), 0);
      chk("rst rd_data", 32'(rd_data), 0);
      rst_n = 1'b1;
      tick();

      // Single press, 2-cycle latency.
      press(9'h01C);
      tick();
      chk("a rd_data", 32'(rd_data), 32'h61);
      chk("a empty", 32'(empty), 0);
      chk("a count", 32'(count), 1);
      pop();
      chk("a popped", 32'(empty), 1);

      // Shift and Caps interplay.
      key_down[9'h012] = 1'b1;
      press(9'h01C); tick();
      chk("shift A", 32'(rd_data), 32'h41);
      pop();
      press(9'h058);
      release_key(9'h058);
      chk("caps toggled", 32'(caps_on), 1);
      press(9'h01C); tick();
      chk("shift+caps a", 32'(rd_data), 32'h61);
      pop();
      key_down[9'h012] = 1'b0;
      press(9'h01C); tick();
      chk("caps A", 32'(rd_data), 32'h41);
      pop();

      // Caps typematic: toggles exactly once.
      do_reset();
      key_down[9'h058] = 1'b1;
      last_change = 9'h058;
      key_valid = 1'b1;
      tick(); tick(); tick();
      key_valid = 1'b0;
      release_key(9'h058);
      tick(); tick();
      chk("caps once", 32'(caps_on), 1);
      chk("caps no char", 32'(count), 0);

      // Shifted digit, keypad enter, unmapped extended code.
`ifdef SHIFT_SYMBOLS_EN
      exp_sym = 8'h21;
`else
      exp_sym = 8'h31;
`endif
      key_down[9'h012] = 1'b1;
      press(9'h016); tick();
      chk("shift 1", 32'(rd_data), 32'(exp_sym));
      pop();
      key_down[9'h012] = 1'b0;
      press(9'h15A); tick();
      chk("kp enter", 32'(rd_data), 32'h0D);
      pop();
      press(9'h174); tick(); tick();
      chk("ext none", 32'(empty), 1);

      // Overflow: 17 pushes into 16 entries.
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) press(let_codes[i]);
      tick(); tick();
      chk("ovf full", 32'(full), 1);
      chk("ovf count", 32'(count), 16);
      chk("ovf flag", 32'(overflow), 1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain order", 32'(rd_data), 32'h61 + i);
         pop();
      end
      chk("drained", 32'(empty), 1);

      // Simultaneous push/pop while full, then reset mid-stream.
      do_reset();
      for (int i = 0; i < DEPTH; i++) press(let_codes[i]);
      tick(); tick();
      chk("refill full", 32'(full), 1);
      press(9'h01A);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      tick();
      chk("pp count", 32'(count), 16);
      chk("pp no ovf", 32'(overflow), 0);
      chk("pp head", 32'(rd_data), 32'h62);
      press(9'h058);
      release_key(9'h058);
      chk("pre-rst caps", 32'(caps_on), 1);
      press(9'h032);
      do_reset();
      chk("mid rst count", 32'(count), 0);
      chk("mid rst empty", 32'(empty), 1);
      chk("mid rst caps", 32'(caps_on), 0);
      tick(); tick();

      // Random traffic against the model.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic [8:0] code;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 5)      code = let_codes[$urandom_range(0, 25)];
         else if (sel < 7) code = dig_codes[$urandom_range(0, 9)];
         else              code = misc_codes[$urandom_range(0, 7)];
         if ($urandom_range(0, 15) == 0) key_down[9'h012] = ~key_down[9'h012];
         if ($urandom_range(0, 31) == 0) key_down[9'h059] = ~key_down[9'h059];
         key_valid = ($urandom_range(0, 2) == 0);
         if (key_valid) begin
            last_change    = code;
            key_down[code] = ($urandom_range(0, 3) != 0);
         end
         // Alternate slow and fast reader phases so the FIFO both fills and drains.
         if ((cyc / 500) % 2 == 0) rd_en = ($urandom_range(0, 9) == 0);
         else                      rd_en = ($urandom_range(0, 2) != 0);
         rst_n = ($urandom_range(0, 999) != 0);
         tick();
      end
      key_valid = 1'b0;
      rd_en = 1'b0;
      rst_n = 1'b1;
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keystroke_char_buffer.md
Name: keystroke_char_buffer

Overview:
- Sits directly downstream of the PS/2 keyboard decoder. Consumes its `key_valid` pulse, `last_change` code and `key_down` bitmap.
- Converts key-press events (scan code set 2) into 8-bit ASCII, applying Shift and a Caps Lock toggle.
- Queues the characters in a show-ahead FIFO, which the text-writing/display logic pops at its own pace.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- key_valid  input  1  one-cycle event pulse from the decoder
- last_change  input  9  {extend, scan_code} of the event
- key_down  input  512  held-key bitmap, already updated in the `key_valid` cycle
- rd_en  input  1  pop request
- rd_data  output  8  ASCII at FIFO head; valid while `empty`=0
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  AW+1  occupancy, 0..DEPTH
- caps_on  output  1  current Caps Lock state
- overflow  output  1  sticky flag: a character was dropped

Behaviour:
- Reset (`rst_n`=0 at a `clk` edge):
  - `count`=0, `empty`=1, `full`=0, `overflow`=0, `caps_on`=0, `rd_data`=8'h00.
  - Capture stage and Caps FSM are cleared.
  - Reset mid-operation discards all queued characters.
- Press event: `key_valid`=1 and `key_down[last_change]`=1. A release event (bit = 0) never produces a character.
- shift = `key_down[9'h012]` | `key_down[9'h059]`.
- Letter case: upper = shift XOR `caps_on`.
- Map for non-extended codes:
  - Letters A–Z (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A) give 'a'..'z' or 'A'..'Z'.
  - Digits 0–9 (45,16,1E,26,25,2E,36,3D,3E,46) give '0'..'9'.
  - 029 gives 0x20; 05A and 15A give 0x0D; 066 gives 0x08.
  - All other codes, including extended ones except 15A, produce no character.
- Pipeline:
  - Cycle N: event sampled; ASCII and a push flag are registered.
  - Cycle N+1: FIFO write.
  - Cycle N+2: `empty`=0, `count` incremented, `rd_data` shows the head.
  - Total latency from `key_valid` to visible data is 2 cycles.
- Typematic repeats (repeated press events while the key is held) each push a character.
- Caps FSM:
  - States CAPS_IDLE and CAPS_HELD.
  - In IDLE, a press of 9'h058 toggles `caps_on` and moves to HELD.
  - In HELD, repeated 058 presses are ignored.
  - In HELD, a release of 058 (`key_valid`=1, `last_change`=058, bit=0) returns to IDLE.
  - Caps Lock itself never pushes a character.
- FIFO:
  - Show-ahead; `rd_en` pops the head at the clock edge.
  - `rd_en` while empty is ignored.
  - Push while full, with no simultaneous pop: the character is dropped, `overflow` is set and stays 1 until reset.
  - Push and pop in the same cycle while full: both occur, `count` unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop ignored, push occurs.
  - Pointers wrap modulo DEPTH.
  - `full` = (`count` == DEPTH).

Optional Feature:
- Macro: SHIFT_SYMBOLS_EN.
- Defined: with shift=1, digit keys 1,2,3,4,5,6,7,8,9,0 map to '!','@','#','$','%','^','&','*','(',')'. Caps Lock does not affect them.
- Undefined: digits always map to '0'..'9' regardless of shift.

Decomposition:
- Shared package `keyboard_char_pkg` holds:
  - 9-bit scan code constants: SC_LSHIFT, SC_RSHIFT, SC_CAPS, SC_ENTER, SC_KP_ENTER, SC_SPACE, SC_BKSP.
  - ASCII constants: ASCII_CR, ASCII_BS, ASCII_SP.
  - Caps FSM state encoding.
- Scan-to-ASCII mapping is a combinational function inside this block.
- One sub-module, `char_fifo`: parameterised DEPTH×8 show-ahead FIFO with count/full/empty and the simultaneous push/pop rules above.

Test Plan:
- Reset then one press of 01C (`key_down[01C]`=1) at cycle N → `rd_data`=0x61 and `empty`=0 at N+2, `count`=1. Pop with `rd_en` → `empty`=1.
- Hold `key_down[012]`=1, press 01C → 0x41. Toggle Caps (press then release 058), press 01C with shift still held → 0x61. Release shift, press 01C → 0x41.
- Three repeated 058 press events then one release → `caps_on` toggles exactly once, to 1. No characters are queued.
- Press 16 with shift=1 → 0x21 when SHIFT_SYMBOLS_EN is defined, 0x31 when undefined. Press 15A → 0x0D. Press 174 → nothing queued.
- Push DEPTH+1 presses with no reads → `full`=1, `count`=16, `overflow`=1. Drain → data in order, with the 17th character absent.
- With FIFO full, assert `rd_en` in the same cycle as a write → `count` stays 16, `overflow` stays 0. Assert `rst_n`=0 mid-stream → next cycle `count`=0, `empty`=1, `caps_on`=0.
